rom_download_router: RTL and testbench
======================================

// Module: rom_download_router
// PURPOSE
//  Sits between hps_io ioctl download bus and the sdram controller / core dl_* bus.
//  - Decodes each downloaded ROM byte by address region.
//  - Buffers writes in a small FIFO.
//  - Issues toggle-style port1/port2 write requests, one outstanding per port, waiting on ack.
//  - Raises rom_loaded once the image is fully committed; the reset generator gates core reset with it.
// PARAMETERS
//  FIFO_DEPTH  4         entries in byte write queue (power of 2, >=2)
//  SP_BASE     'h10000   first byte address of sprite region (routed to port2)
//  SP_END      'h1C000   first byte address past sprite region
//  IMG_END     'h1C320   first byte address past ROM image; bytes >= IMG_END are dropped
//  ROM_INDEX   0         ioctl_index value for ROM image; other indices ignored (DIP=254 handled elsewhere)
// PORTS
//  clk             in   1   clk_sd domain clock
//  reset           in   1   synchronous, active-high
//  ioctl_download  in   1   download window active
//  ioctl_wr        in   1   byte strobe (level; rising edge = one byte)
//  ioctl_addr      in   25  byte address
//  ioctl_dout      in   8   byte data
//  ioctl_index     in   8   download index
//  port1_req       out  1   toggle request, main/snd/gfx1 region
//  port1_ack       in   1   equals port1_req when write done
//  port1_a         out  23  16-bit word address = addr[23:1]
//  port1_ds        out  2   {addr[0], ~addr[0]}
//  port1_d         out  16  {byte, byte}
//  port2_req       out  1   toggle request, sprite region
//  port2_ack       in   1   equals port2_req when write done
//  port2_a         out  23  {o[23:16], o[13:0], o[15]}, o = addr - SP_BASE
//  port2_ds        out  2   {o[14], ~o[14]}
//  port2_d         out  16  {byte, byte}
//  port_we         out  1   = ioctl_download (registered)
//  dl_wr           out  1   1-cycle strobe to core local ROMs, every accepted byte < IMG_END
//  dl_addr         out  17  byte address [16:0]
//  dl_data         out  8   byte
//  rom_loaded      out  1   sticky; image committed
//  overflow        out  1   sticky; byte arrived with FIFO full (byte dropped)
// BEHAVIOUR
//  Reset values
//  - All outputs 0. port*_req = 0, FIFO empty.
//  - rom_loaded and overflow clear; they are cleared only by reset.
//  Accept
//  - Cycle N: rising edge of ioctl_wr with ioctl_download=1, index=ROM_INDEX, addr<IMG_END.
//  - N+1: dl_wr pulses with addr/data.
//  - If addr<SP_END, the byte is also enqueued at N+1.
//  Dispatch
//  - FIFO is in-order. Head targets port2 if SP_BASE<=addr<SP_END, else port1.
//  - Head issues when its port is idle (req==ack): drive a/ds/d, toggle req.
//  - Earliest toggle is N+2. Pop on issue.
//  - Next head may issue the following cycle if its port is idle; otherwise it blocks (no reordering).
//  - Port outputs hold until the next issue.
//  Boundaries
//  - Push and pop in the same cycle are both performed; count is unchanged.
//  - FIFO full with no pop: byte dropped, overflow=1. dl_wr still fires.
//  - Address pointers wrap modulo FIFO_DEPTH.
//  - Byte exactly at SP_BASE goes to port2 with o=0. Byte at SP_END-1 goes to port2. Byte at SP_END: dl only.
//  rom_loaded
//  - Set 1 cycle after all hold: download has fallen (latched), FIFO empty, port1_req==port1_ack, port2_req==port2_ack.
//  - A new download clears the latched fall; rom_loaded stays 1.
//  Reset mid-download
//  - FIFO flushed. Outstanding toggles are abandoned: req returns to 0.
//  - sdram must tolerate this; the host re-downloads.
// TESTING
//  1. Write 0x00000=AA -> dl_wr@N+1 addr 0; port1_req toggles@N+2, port1_a=0, ds=01, d=AAAA.
//  2. Write 0x10000=11, 0x14001=22 -> port2_a 0 ds=01, then o=0x4001 -> a=0x00002 ds=10.
//  3. 6 back-to-back bytes, ack held off 20 cycles, DEPTH=4 -> 4 queued + 1 issued, 6th dropped, overflow=1.
//  4. Byte at 0x1C100 -> dl_wr only, no req. Byte at 0x1C320 -> nothing.
//  5. ioctl_download falls with port1 pending -> rom_loaded rises 1 cycle after ack matches.
//  6. Reset asserted with 3 queued -> all outputs 0 next cycle; no further req toggles.

Source files
------------

// File: rtl/rom_download_router.sv
// ROM download router: decodes ioctl download bytes by address region, queues
// sdram word writes in a small in-order FIFO, drives toggle-style port1/port2
// requests (one outstanding per port) and reports when the image is committed.
module rom_download_router #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [24:0] SP_BASE    = 25'h10000,
    parameter logic [24:0] SP_END     = 25'h1C000,
    parameter logic [24:0] IMG_END    = 25'h1C320,
    parameter logic [7:0]  ROM_INDEX  = 8'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    output logic        port1_req,
    input  logic        port1_ack,
    output logic [22:0] port1_a,
    output logic [1:0]  port1_ds,
    output logic [15:0] port1_d,
    output logic        port2_req,
    input  logic        port2_ack,
    output logic [22:0] port2_a,
    output logic [1:0]  port2_ds,
    output logic [15:0] port2_d,
    output logic        port_we,
    output logic        dl_wr,
    output logic [16:0] dl_addr,
    output logic [7:0]  dl_data,
    output logic        rom_loaded,
    output logic        overflow
);

    localparam int             PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    // Byte queue storage; only addresses below SP_END are ever queued, so 17 bits suffice.
    logic [16:0]      mem_addr [FIFO_DEPTH];
    logic [7:0]       mem_data [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [PTR_W:0]   count_q, count_d;

    logic        wr_q;        // previous ioctl_wr, for rising-edge detection
    logic        port_we_q;   // registered ioctl_download, also the previous download level
    logic        fell_q;      // download window has closed since the last one opened
    logic        rom_loaded_q, overflow_q;
    logic        dl_wr_q;
    logic [16:0] dl_addr_q;
    logic [7:0]  dl_data_q;
    logic        p1_req_q, p2_req_q;
    logic [22:0] p1_a_q, p2_a_q;
    logic [1:0]  p1_ds_q, p2_ds_q;
    logic [15:0] p1_d_q, p2_d_q;

    logic        accept, enq, push, pop;
    logic        fifo_empty, fifo_full;
    logic        p1_idle, p2_idle, head_sp;
    logic [24:0] head_addr;
    logic [7:0]  head_data;
    logic [23:0] sp_off;

    // Accept/route decode, FIFO head decode and push/pop arbitration.
    always_comb begin
        accept     = ioctl_wr & ~wr_q & ioctl_download &
                     (ioctl_index == ROM_INDEX) & (ioctl_addr < IMG_END);
        enq        = accept & (ioctl_addr < SP_END);
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == DEPTH_C);
        p1_idle    = (p1_req_q == port1_ack);
        p2_idle    = (p2_req_q == port2_ack);
        head_addr  = {8'b0, mem_addr[rd_ptr_q]};
        head_data  = mem_data[rd_ptr_q];
        head_sp    = (head_addr >= SP_BASE);
        sp_off     = head_addr[23:0] - SP_BASE[23:0];
        // The head blocks on its own port only; later entries never overtake it.
        pop        = ~fifo_empty & (head_sp ? p2_idle : p1_idle);
        // A full queue still accepts a byte when the head leaves in the same cycle.
        push       = enq & (~fifo_full | pop);
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Queue storage write; contents are don't-care while the entry is not counted.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr_q] <= ioctl_addr[16:0];
            mem_data[wr_ptr_q] <= ioctl_dout;
        end
    end

    // Control, dispatch and status registers; reset abandons queued and outstanding writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q         <= 1'b0;
            port_we_q    <= 1'b0;
            fell_q       <= 1'b0;
            rom_loaded_q <= 1'b0;
            overflow_q   <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            dl_wr_q      <= 1'b0;
            dl_addr_q    <= '0;
            dl_data_q    <= '0;
            p1_req_q     <= 1'b0;
            p1_a_q       <= '0;
            p1_ds_q      <= '0;
            p1_d_q       <= '0;
            p2_req_q     <= 1'b0;
            p2_a_q       <= '0;
            p2_ds_q      <= '0;
            p2_d_q       <= '0;
        end else begin
            wr_q      <= ioctl_wr;
            port_we_q <= ioctl_download;
            if (ioctl_download & ~port_we_q) begin
                fell_q <= 1'b0;
            end else if (~ioctl_download & port_we_q) begin
                fell_q <= 1'b1;
            end
            if (fell_q & fifo_empty & p1_idle & p2_idle) begin
                rom_loaded_q <= 1'b1;
            end
            if (enq & fifo_full & ~pop) begin
                overflow_q <= 1'b1;
            end
            dl_wr_q <= accept;
            if (accept) begin
                dl_addr_q <= ioctl_addr[16:0];
                dl_data_q <= ioctl_dout;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                if (head_sp) begin
                    p2_req_q <= ~p2_req_q;
                    p2_a_q   <= {sp_off[23:16], sp_off[13:0], sp_off[15]};
                    p2_ds_q  <= {sp_off[14], ~sp_off[14]};
                    p2_d_q   <= {head_data, head_data};
                end else begin
                    p1_req_q <= ~p1_req_q;
                    p1_a_q   <= head_addr[23:1];
                    p1_ds_q  <= {head_addr[0], ~head_addr[0]};
                    p1_d_q   <= {head_data, head_data};
                end
            end
            count_q <= count_d;
        end
    end

    assign port1_req  = p1_req_q;
    assign port1_a    = p1_a_q;
    assign port1_ds   = p1_ds_q;
    assign port1_d    = p1_d_q;
    assign port2_req  = p2_req_q;
    assign port2_a    = p2_a_q;
    assign port2_ds   = p2_ds_q;
    assign port2_d    = p2_d_q;
    assign port_we    = port_we_q;
    assign dl_wr      = dl_wr_q;
    assign dl_addr    = dl_addr_q;
    assign dl_data    = dl_data_q;
    assign rom_loaded = rom_loaded_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_rom_download_router.sv
// Bench for rom_download_router: directed boundary steps plus a randomized
// phase, checked against a queue-based model of the expected writes.
module tb_rom_download_router;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, ioctl_download, ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout, ioctl_index;
    logic        port1_req, port2_req;
    logic        port1_ack = 1'b0, port2_ack = 1'b0;
    logic [22:0] port1_a, port2_a;
    logic [1:0]  port1_ds, port2_ds;
    logic [15:0] port1_d, port2_d;
    logic        port_we, dl_wr, rom_loaded, overflow;
    logic [16:0] dl_addr;
    logic [7:0]  dl_data;

    rom_download_router dut (
        .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
        .port1_req(port1_req), .port1_ack(port1_ack), .port1_a(port1_a),
        .port1_ds(port1_ds), .port1_d(port1_d),
        .port2_req(port2_req), .port2_ack(port2_ack), .port2_a(port2_a),
        .port2_ds(port2_ds), .port2_d(port2_d),
        .port_we(port_we), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
        .rom_loaded(rom_loaded), .overflow(overflow)
    );

    int checks = 0, failures = 0;
    logic [40:0] exp_p1[$], exp_p2[$];   // {a, ds, d}
    logic [24:0] exp_dl[$];              // {addr[16:0], byte}
    int p1_toggles = 0, p2_toggles = 0, dl_seen = 0;
    bit hold1 = 0, hold2 = 0;
    int dly1 = 0, dly2 = 0, cnt1 = 0, cnt2 = 0;
    logic p1_prev = 1'b0, p2_prev = 1'b0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected word write for a main-region byte.
    function automatic logic [40:0] p1_exp(input int a, input logic [7:0] b);
        logic [22:0] w;
        w = 23'(a / 2);
        return {w, (a % 2 == 1) ? 2'b10 : 2'b01, b, b};
    endfunction

    // Expected word write for a sprite-region byte.
    function automatic logic [40:0] p2_exp(input int a, input logic [7:0] b);
        int o;
        logic [22:0] w;
        o = a - 'h10000;
        w = 23'((((o / 65536) % 256) * 32768) + ((o % 16384) * 2) + ((o / 32768) % 2));
        return {w, ((o / 16384) % 2 == 1) ? 2'b10 : 2'b01, b, b};
    endfunction

    // sdram model: ack follows req after a programmable delay unless held off.
    always @(negedge clk) begin
        if (port1_ack !== port1_req && !hold1) begin
            if (cnt1 >= dly1) begin port1_ack = port1_req; cnt1 = 0; end else cnt1++;
        end
        if (port2_ack !== port2_req && !hold2) begin
            if (cnt2 >= dly2) begin port2_ack = port2_req; cnt2 = 0; end else cnt2++;
        end
    end

    // Scoreboard: every dl_wr and every req toggle must match the next expected entry.
    always @(negedge clk) begin
        if (reset) begin
            p1_prev = port1_req;
            p2_prev = port2_req;
            exp_p1.delete(); exp_p2.delete(); exp_dl.delete();
        end else begin
            if (dl_wr) begin
                dl_seen++;
                if (exp_dl.size() == 0) check("dl_unexpected", dl_wr, 0);
                else check("dl_content", {dl_addr, dl_data}, exp_dl.pop_front());
            end
            if (port1_req !== p1_prev) begin
                p1_toggles++;
                if (exp_p1.size() == 0) check("p1_unexpected", port1_req ^ p1_prev, 0);
                else check("p1_content", {port1_a, port1_ds, port1_d}, exp_p1.pop_front());
                p1_prev = port1_req;
            end
            if (port2_req !== p2_prev) begin
                p2_toggles++;
                if (exp_p2.size() == 0) check("p2_unexpected", port2_req ^ p2_prev, 0);
                else check("p2_content", {port2_a, port2_ds, port2_d}, exp_p2.pop_front());
                p2_prev = port2_req;
            end
        end
    end

    // One byte strobe held hold_n cycles; returns at the negedge after the accepting edge.
    task automatic write_byte(input int a, input logic [7:0] b, input bit to_port, input int hold_n);
        @(negedge clk);
        ioctl_addr = 25'(a);
        ioctl_dout = b;
        ioctl_wr   = 1'b1;
        if (ioctl_download && ioctl_index == 8'd0 && a < 'h1C320) begin
            exp_dl.push_back({17'(a), b});
            if (to_port && a < 'h1C000) begin
                if (a >= 'h10000) exp_p2.push_back(p2_exp(a, b));
                else exp_p1.push_back(p1_exp(a, b));
            end
        end
        repeat (hold_n) @(negedge clk);
        ioctl_wr = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_p1"}, {port1_req, port1_a, port1_ds, port1_d}, 0);
        check({tag, "_p2"}, {port2_req, port2_a, port2_ds, port2_d}, 0);
        check({tag, "_misc"}, {port_we, dl_wr, dl_addr, dl_data, rom_loaded, overflow}, 0);
    endtask

    initial begin
        int s1, s2, sd;
        int bnd [6];
        bnd = '{'h10000, 'h1BFFF, 'h1C000, 'h1C31F, 'h1C320, 'h0FFFF};
        reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0; ioctl_index = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        ioctl_download = 1'b1;
        @(negedge clk);
        check("port_we", port_we, 1);

        // First byte: dl strobe at N+1, port1 toggle at N+2.
        write_byte('h00000, 8'hAA, 1, 1);
        check("t1_dl", {dl_wr, dl_addr, dl_data}, {1'b1, 17'h0, 8'hAA});
        check("t1_req_early", port1_req, 0);
        @(negedge clk);
        check("t1_req", port1_req, 1);
        check("t1_port", {port1_a, port1_ds, port1_d}, {23'h0, 2'b01, 16'hAAAA});
        check("t1_dl_end", dl_wr, 0);

        // Sprite region addressing.
        write_byte('h10000, 8'h11, 1, 1);
        write_byte('h14001, 8'h22, 1, 1);
        repeat (8) @(negedge clk);
        check("t2_port2", {port2_a, port2_ds, port2_d}, {23'h2, 2'b10, 16'h2222});
        check("t2_toggles", p2_toggles, 2);

        // Region edges, non-image bytes and ignored index.
        s1 = p1_toggles; s2 = p2_toggles; sd = dl_seen;
        write_byte('h1BFFF, 8'h55, 1, 1);
        write_byte('h0FFFF, 8'h56, 1, 1);
        write_byte('h1C100, 8'h33, 1, 1);
        write_byte('h1C320, 8'h44, 1, 1);
        ioctl_index = 8'd1;
        write_byte('h00100, 8'h45, 1, 1);
        ioctl_index = 8'd0;
        repeat (6) @(negedge clk);
        check("t4_dl_count", dl_seen, sd + 3);
        check("t4_p1_toggles", p1_toggles, s1 + 1);
        check("t4_p2_toggles", p2_toggles, s2 + 1);

        // Download closes with port1 still outstanding.
        hold1 = 1;
        write_byte('h02002, 8'h66, 1, 1);
        repeat (3) @(negedge clk);
        ioctl_download = 1'b0;
        repeat (5) @(negedge clk);
        check("t5_pending", port1_req ^ port1_ack, 1);
        check("t5_not_loaded", rom_loaded, 0);
        @(posedge clk); #1;
        dly1 = 0; hold1 = 0;
        @(negedge clk);
        check("t5_loaded_early", rom_loaded, 0);
        @(negedge clk);
        check("t5_loaded", rom_loaded, 1);
        ioctl_download = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_sticky", rom_loaded, 1);

        // Overflow: one issued, four queued, sixth byte dropped.
        hold1 = 1;
        s1 = p1_toggles;
        for (int i = 0; i < 5; i++) write_byte('h3000 + 2 * i, 8'(8'h70 + i), 1, 1);
        check("t3_no_ovf", overflow, 0);
        write_byte('h300A, 8'h75, 0, 1);
        check("t3_ovf", overflow, 1);
        check("t3_one_issued", p1_toggles, s1 + 1);
        repeat (20) @(negedge clk);
        dly1 = 2; hold1 = 0;
        for (int i = 0; i < 200 && exp_p1.size() != 0; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        check("t3_drained", exp_p1.size(), 0);
        check("t3_issued", p1_toggles, s1 + 5);
        check("t3_ovf_sticky", overflow, 1);

        // Reset with entries queued abandons everything.
        hold1 = 1;
        s1 = p1_toggles;
        for (int i = 0; i < 4; i++) write_byte('h4000 + 2 * i, 8'(8'h80 + i), 1, 1);
        check("t6_one_issued", p1_toggles, s1 + 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("t6_reset");
        @(negedge clk);
        reset = 1'b0;
        hold1 = 0;
        s1 = p1_toggles;
        repeat (20) @(negedge clk);
        check("t6_no_toggle", p1_toggles, s1);
        check("t6_req", {port1_req, port2_req}, 0);

        // Randomized traffic paced so the queue never fills.
        for (int i = 0; i < 40; i++) begin
            int r, a;
            r = $urandom_range(0, 9);
            dly1 = $urandom_range(0, 4);
            dly2 = $urandom_range(0, 4);
            if (r < 4)       a = $urandom_range(0, 'hFFFF);
            else if (r < 7)  a = $urandom_range('h10000, 'h1BFFF);
            else if (r == 7) a = $urandom_range('h1C000, 'h1C31F);
            else if (r == 8) a = $urandom_range('h1C320, 'h1C420);
            else             a = bnd[$urandom_range(0, 5)];
            ioctl_index = ($urandom_range(0, 7) == 0) ? 8'd1 : 8'd0;
            write_byte(a, 8'($urandom), 1, $urandom_range(1, 3));
            repeat ($urandom_range(7, 9)) @(negedge clk);
        end
        ioctl_index = 8'd0;
        ioctl_download = 1'b0;
        for (int i = 0; i < 100 && !rom_loaded; i++) @(negedge clk);
        check("rnd_loaded", rom_loaded, 1);
        check("rnd_no_ovf", overflow, 0);
        check("rnd_all_seen", exp_p1.size() + exp_p2.size() + exp_dl.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
